avg_window: RTL
===============

Name: avg_window

Overview:
- Parametrised sliding-window averager; successor to the fixed 8-sample, 8-bit average block.
- Keeps the last 2^LOG2_DEPTH accepted samples in a circular register buffer and a running sum.
- Outputs the window mean with selectable truncate/round and a selectable fill policy.
- Sits in the sample datapath between an upstream source with a valid strobe and downstream logic that consumes averaged values.

Parameters:
- WIDTH, 8, sample and average width in bits (≥2).
- LOG2_DEPTH, 3, log2 of window depth; DEPTH = 2^LOG2_DEPTH (1..8).
- ROUND, 0, 0 = truncate (floor); 1 = round half up.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rs  in  1  reset; synchronous, active-high.
- clear  in  1  synchronous window flush.
- in_valid  in  1  num_in is accepted this cycle.
- num_in  in  WIDTH  unsigned input sample.
- wait_full  in  1  fill policy: 0 = emit from first sample; 1 = suppress until window full.
- ave_out  out  WIDTH  registered window average.
- out_valid  out  1  one-cycle pulse; ave_out is new.
- full  out  1  window holds DEPTH samples.
- count  out  LOG2_DEPTH+1  accepted samples in window, saturating at DEPTH.

Behaviour:
- One clock domain. Reset is synchronous and active-high.
- Reset (rs=1 at a rising edge): ave_out=0, out_valid=0, full=0, count=0, sum=0, write pointer=0. Buffer contents are don't-care. rs overrides clear and in_valid.
- Internal state:
  - Buffer: DEPTH x WIDTH registers.
  - wptr: LOG2_DEPTH bits; wraps DEPTH-1 -> 0.
  - sum: WIDTH+LOG2_DEPTH+1 bits, unsigned; cannot overflow.
- Fill states, derived from count:
  - FILLING: count < DEPTH.
  - FULL: count == DEPTH. full = (count == DEPTH).
  - Only rs or clear leaves FULL.
- Accept (in_valid=1, rs=0, clear=0):
  - old = buf[wptr] if FULL, else 0. Stale buffer data is never subtracted.
  - sum_n = sum + num_in - old.
  - buf[wptr] = num_in; wptr++.
  - count = min(count+1, DEPTH).
- Average of sum_n:
  - ROUND=0: sum_n >> LOG2_DEPTH.
  - ROUND=1: (sum_n + DEPTH/2) >> LOG2_DEPTH. Saturates at 2^WIDTH-1, which is never exceeded given the widths.
  - In FILLING, the missing samples count as zero; the divisor is always DEPTH.
- Latency: ave_out and out_valid register one cycle after the accepting edge. No combinational input-to-output path.
- Output rules:
  - wait_full=0: out_valid pulses after every accept.
  - wait_full=1: out_valid pulses only for accepts where the post-update count == DEPTH. ave_out still updates every accept.
  - out_valid is 0 on idle cycles (in_valid=0). ave_out holds its value.
- clear=1 (rs=0):
  - sum=0, count=0, wptr=0, full=0. ave_out is held. out_valid=0 unless a sample is accepted the same cycle.
  - clear and in_valid together: the sample is taken as the first sample of a fresh window (old=0, sum_n=num_in, count=1, wptr=1). ave_out/out_valid follow the normal rules using that sum.
- wait_full may change at any cycle and is sampled on the accepting edge.
- Back-to-back accepts every cycle are supported at full rate; there is no stall.

Test Plan:
- Reset and first sample: rs=1 for 2 cycles, then one accept of 200 (defaults) -> during reset all outputs 0; one cycle after the accept ave_out=25, out_valid=1, count=1, full=0.
- Window fill and slide (defaults):
  - Accept 200,100,200,255,91,25,100,25 -> after 8th: ave_out=124 (sum 996), full=1, count=8.
  - Then accept 24 -> ave_out=102 (sum 820, 200 evicted).
- Rounding: same sequence with ROUND=1 -> 8th result 125, then 103; the first sample alone gives 25.
- wait_full=1: 8-sample sequence -> out_valid stays 0 for samples 1-7, pulses on sample 8 with 124, then pulses on every later accept.
- Clear and gaps:
  - Gaps: insert idle cycles between accepts -> no out_valid, ave_out held.
  - Clear while full plus simultaneous accept of 80 -> ave_out=10, count=1, full=0; previous window contents do not affect later averages.
  - Clear with no accept -> ave_out held, out_valid=0.
- Reset mid-operation and parametrisation:
  - rs asserted with in_valid=1 and clear=1 in FULL -> all outputs 0 next cycle, sample dropped.
  - Rerun with WIDTH=12, LOG2_DEPTH=2: four samples of 4095 -> ave_out=4095, with no overflow under either ROUND setting.

Source files
------------

// File: rtl/avg_window.sv
// Sliding-window mean over the last 2^LOG2_DEPTH accepted samples, truncate or round-half-up.
// Latency: 1 cycle from accepting edge to ave_out/out_valid; no backpressure, accepts every cycle.
module avg_window #(
    parameter int WIDTH      = 8,
    parameter int LOG2_DEPTH = 3,
    parameter bit ROUND      = 1'b0
) (
    input  logic                  clk,
    input  logic                  rs,
    input  logic                  clear,
    input  logic                  in_valid,
    input  logic [WIDTH-1:0]      num_in,
    input  logic                  wait_full,
    output logic [WIDTH-1:0]      ave_out,
    output logic                  out_valid,
    output logic                  full,
    output logic [LOG2_DEPTH:0]   count
);

    localparam int DEPTH = 1 << LOG2_DEPTH;
    localparam int SW    = WIDTH + LOG2_DEPTH + 1;
    localparam int CW    = LOG2_DEPTH + 1;

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [SW-1:0] RND_C   = ROUND ? SW'(DEPTH / 2) : '0;

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [LOG2_DEPTH-1:0] wptr;
    logic [SW-1:0]         sum;

    logic [LOG2_DEPTH-1:0] wr_idx;
    logic [SW-1:0]         base_sum;
    logic [SW-1:0]         old_ext;
    logic [SW-1:0]         in_ext;
    logic [SW-1:0]         sum_n;
    logic [SW-1:0]         rounded;
    logic [SW-1:0]         shifted;
    logic [WIDTH-1:0]      avg_n;
    logic [CW-1:0]         cnt_base;
    logic [CW-1:0]         cnt_n;

    assign full = (count == DEPTH_C);

    // A clear in the same cycle as an accept starts a fresh window, so the
    // accepted sample sees zero history regardless of the old state.
    always_comb begin
        wr_idx   = clear ? '0 : wptr;
        base_sum = clear ? '0 : sum;
        cnt_base = clear ? '0 : count;
        in_ext   = {{(SW-WIDTH){1'b0}}, num_in};
        old_ext  = '0;
        if (full && !clear) begin
            old_ext = {{(SW-WIDTH){1'b0}}, mem[wptr]};
        end
        sum_n   = base_sum + in_ext - old_ext;
        cnt_n   = (cnt_base == DEPTH_C) ? DEPTH_C : cnt_base + 1'b1;
        rounded = sum_n + RND_C;
        shifted = rounded >> LOG2_DEPTH;
        avg_n   = shifted[WIDTH-1:0];
        if (shifted[SW-1:WIDTH] != '0) begin
            avg_n = '1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rs && in_valid) begin
            mem[wr_idx] <= num_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rs) begin
            wptr      <= '0;
            sum       <= '0;
            count     <= '0;
            ave_out   <= '0;
            out_valid <= 1'b0;
        end else if (in_valid) begin
            wptr      <= wr_idx + 1'b1;
            sum       <= sum_n;
            count     <= cnt_n;
            ave_out   <= avg_n;
            out_valid <= !wait_full || (cnt_n == DEPTH_C);
        end else begin
            out_valid <= 1'b0;
            if (clear) begin
                wptr  <= '0;
                sum   <= '0;
                count <= '0;
            end
        end
    end

endmodule
